// File: rtl/commit_checker_if.sv
// Command/response channel between a host (bench or debug port) and commit_checker.
// Host drives through the master modport; the checker serves through the slave modport.
interface commit_checker_if #(
    parameter int XLEN      = 32,
    parameter int RW        = 5,
    parameter int TIMEOUT_W = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [RW-1:0]        cmd_reg;
    logic [XLEN-1:0]      cmd_data;
    logic [XLEN-1:0]      cmd_mask;
    logic [TIMEOUT_W-1:0] cmd_timeout;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_pass;
    logic                 rsp_timeout;
    logic [XLEN-1:0]      rsp_got;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_data, cmd_mask, cmd_timeout, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_pass, rsp_timeout, rsp_got
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_data, cmd_mask, cmd_timeout, rsp_ready,
        output cmd_ready, rsp_valid, rsp_pass, rsp_timeout, rsp_got
    );
endinterface

// File: rtl/commit_checker.sv
// Write-back snooping monitor: shadow register file plus CHECK/WAIT/CLEAR command server.
// Optional macro COMMIT_CHECKER_HALT_EN adds a sticky 'halted' output that blocks commands after a failure.
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command
// S_EVAL | single-cycle compare for CHECK
// S_WAIT | compare every cycle until match or timeout expiry
// S_RESP | response held until rsp_ready
module commit_checker #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int FLAG_REG  = 20,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    commit_checker_if.slave          bus,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [XLEN-1:0]          flag
`ifdef COMMIT_CHECKER_HALT_EN
    ,
    output logic                     halted
`endif
);
    localparam int RW = $clog2(NREGS);
    localparam logic [RW-1:0] FLAG_IDX = RW'(FLAG_REG);
    localparam logic [1:0] OP_CHECK = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
`ifdef COMMIT_CHECKER_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WAIT, S_RESP} state_t;

    state_t               state;
    logic [XLEN-1:0]      shadow [NREGS];
    logic [1:0]           op_q;
    logic [RW-1:0]        reg_q;
    logic [XLEN-1:0]      data_q;
    logic [XLEN-1:0]      mask_q;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic [XLEN-1:0]      got;
    logic                 match;
    logic                 fail_rsp;
    logic                 halt_q;

    // Entry 0 is never written, so x0 reads as zero without a special read path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            shadow[wb_rd] <= wb_data;
        end
    end

    assign flag     = shadow[FLAG_IDX];
    assign got      = shadow[reg_q];
    assign match    = ((got ^ data_q) & mask_q) == '0;
    assign fail_rsp = (op_q != OP_CLEAR) && !bus.rsp_pass;

`ifdef COMMIT_CHECKER_HALT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (state == S_RESP && bus.rsp_ready && fail_rsp) begin
            halted <= 1'b1;
        end
    end
    assign halt_q = halted;
`else
    assign halt_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            bus.cmd_ready   <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_pass    <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_got     <= '0;
            op_q            <= '0;
            reg_q           <= '0;
            data_q          <= '0;
            mask_q          <= '0;
            tmo_q           <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= bus.cmd_op;
                        reg_q         <= bus.cmd_reg;
                        data_q        <= bus.cmd_data;
                        mask_q        <= bus.cmd_mask;
                        tmo_q         <= bus.cmd_timeout;
                        bus.cmd_ready <= 1'b0;
                        unique case (bus.cmd_op)
                            OP_CHECK: state <= S_EVAL;
                            OP_WAIT:  state <= S_WAIT;
                            default: begin
                                state           <= S_RESP;
                                bus.rsp_valid   <= 1'b1;
                                bus.rsp_pass    <= (bus.cmd_op == OP_CLEAR);
                                bus.rsp_timeout <= 1'b0;
                                bus.rsp_got     <= '0;
                            end
                        endcase
                    end else begin
                        bus.cmd_ready <= !halt_q;
                    end
                end
                S_EVAL: begin
                    bus.rsp_got     <= got;
                    bus.rsp_pass    <= match;
                    bus.rsp_timeout <= 1'b0;
                    bus.rsp_valid   <= 1'b1;
                    state           <= S_RESP;
                end
                S_WAIT: begin
                    // A match wins over expiry in the same cycle; timeout 0 never expires.
                    if (match) begin
                        bus.rsp_got     <= got;
                        bus.rsp_pass    <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= S_RESP;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - TIMEOUT_W'(1);
                        if (tmo_q == TIMEOUT_W'(1)) begin
                            bus.rsp_got     <= got;
                            bus.rsp_pass    <= 1'b0;
                            bus.rsp_timeout <= 1'b1;
                            bus.rsp_valid   <= 1'b1;
                            state           <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= !(halt_q || (HALT_EN && fail_rsp));
                        state         <= S_IDLE;
                        if (op_q == OP_CLEAR) begin
                            pass_cnt <= '0;
                            fail_cnt <= '0;
                        end else if (bus.rsp_pass) begin
                            if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: vector table of single commands plus multi-cycle sequences.
module tb_commit_checker;
    localparam logic [1:0] OP_CHECK = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [15:0] pass_cnt, fail_cnt;
    logic [31:0] flag;
`ifdef COMMIT_CHECKER_HALT_EN
    logic        halted;
`endif

    commit_checker_if #(.XLEN(32), .RW(5), .TIMEOUT_W(16)) bus ();

    commit_checker dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .bus      (bus),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .flag     (flag)
`ifdef COMMIT_CHECKER_HALT_EN
        ,
        .halted   (halted)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] mask;
        logic [15:0] tmo;
        logic        pre_we;
        logic [4:0]  pre_rd;
        logic [31:0] pre_data;
        logic        e_pass;
        logic        e_tmo;
        logic        chk_got;
        logic [31:0] e_got;
        int          e_lat;
    } vec_t;

    vec_t vecs[12];
    int   total = 0;
    int   bad = 0;
    int   m_pc = 0;
    int   m_fc = 0;
    bit   m_halt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        wb_we = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.pass_cnt", 32'(pass_cnt), 32'd0);
        chk("rst.fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst.flag", flag, 32'd0);
`ifdef COMMIT_CHECKER_HALT_EN
        chk("rst.halted", 32'(halted), 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("rst.cmd_ready_held", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        m_pc = 0;
        m_fc = 0;
        m_halt = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
        wb_we = 1'b1;
        wb_rd = rd;
        wb_data = d;
        @(negedge clk);
        wb_we = 1'b0;
    endtask

    // Entered at a negedge; returns at the negedge of the cycle after the handshake.
    task automatic send_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] d,
                            input logic [31:0] m, input logic [15:0] tmo, output bit ok);
        int n;
        bus.cmd_op = op;
        bus.cmd_reg = rg;
        bus.cmd_data = d;
        bus.cmd_mask = m;
        bus.cmd_timeout = tmo;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            expired("cmd_ready");
            bus.cmd_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) expired("rsp_valid");
    endtask

    task automatic finish_rsp(input logic [1:0] op, input logic e_pass, input string tag);
        if (op == OP_CLEAR) begin
            m_pc = 0;
            m_fc = 0;
        end else if (e_pass) m_pc++;
        else begin
            m_fc++;
            m_halt = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(m_pc));
        chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fc));
        chk({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
`ifdef COMMIT_CHECKER_HALT_EN
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(!m_halt));
`else
        chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
`endif
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int lat;
        if (v.pre_we) wb_write(v.pre_rd, v.pre_data);
        send_cmd(v.op, v.rg, v.data, v.mask, v.tmo, ok);
        if (!ok) return;
        wait_rsp(lat);
        chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
        if (!bus.rsp_valid) return;
        chk({tag, ".rsp_pass"}, 32'(bus.rsp_pass), 32'(v.e_pass));
        chk({tag, ".rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.e_tmo));
        if (v.chk_got) chk({tag, ".rsp_got"}, bus.rsp_got, v.e_got);
        finish_rsp(v.op, v.e_pass, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        int early;
        string tag;

        vecs[0]  = '{OP_CHECK, 5'd11, 32'h11223344, 32'hFFFFFFFF, 16'd0,  1'b1, 5'd11, 32'h11223344, 1'b1, 1'b0, 1'b1, 32'h11223344, 2};
        vecs[1]  = '{OP_CHECK, 5'd11, 32'h0000CCDD, 32'h0000FFFF, 16'd0,  1'b1, 5'd11, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 32'hAABBCCDD, 2};
        vecs[2]  = '{OP_CHECK, 5'd11, 32'h0000CCDD, 32'hFFFFFFFF, 16'd0,  1'b1, 5'd11, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 2};
        vecs[3]  = '{OP_CHECK, 5'd0,  32'h00000000, 32'hFFFFFFFF, 16'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h00000000, 2};
        vecs[4]  = '{OP_WAIT,  5'd11, 32'hAABBCCDD, 32'hFFFFFFFF, 16'd0,  1'b1, 5'd11, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 32'hAABBCCDD, 2};
        vecs[5]  = '{OP_WAIT,  5'd20, 32'h00000009, 32'hFFFFFFFF, 16'd10, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00000000, 11};
        vecs[6]  = '{OP_WAIT,  5'd20, 32'h00000009, 32'hFFFFFFFF, 16'd1,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00000000, 2};
        vecs[7]  = '{OP_RSVD,  5'd11, 32'h00000000, 32'hFFFFFFFF, 16'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h00000000, 1};
        vecs[8]  = '{OP_CLEAR, 5'd0,  32'h00000000, 32'h00000000, 16'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h00000000, 1};
        vecs[9]  = '{OP_CHECK, 5'd5,  32'h12345600, 32'hFFFFFF00, 16'd0,  1'b1, 5'd5,  32'h12345678, 1'b1, 1'b0, 1'b1, 32'h12345678, 2};
        vecs[10] = '{OP_WAIT,  5'd5,  32'h12345678, 32'hFFFFFFFF, 16'd1,  1'b1, 5'd5,  32'h12345678, 1'b1, 1'b0, 1'b1, 32'h12345678, 2};
        vecs[11] = '{OP_WAIT,  5'd5,  32'hDEADBEEF, 32'h00000000, 16'd3,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678, 2};

        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_reg = '0;
        bus.cmd_data = '0;
        bus.cmd_mask = '0;
        bus.cmd_timeout = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("init.rsp_pass", 32'(bus.rsp_pass), 32'd0);
        chk("init.rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("init.rsp_got", bus.rsp_got, 32'd0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i], tag);
`ifdef COMMIT_CHECKER_HALT_EN
            if (m_halt) begin
                bus.cmd_op = OP_CHECK;
                bus.cmd_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk({tag, ".halt_blocks"}, 32'(bus.cmd_ready), 32'd0);
                end
                bus.cmd_valid = 1'b0;
                do_reset();
                @(negedge clk);
                chk({tag, ".halt_cleared"}, 32'(halted), 32'd0);
            end
`endif
        end

        // Response held under backpressure, then CLEAR.
        wb_write(5'd0, 32'hFFFFFFFF);
        send_cmd(OP_CHECK, 5'd0, 32'h0, 32'hFFFFFFFF, 16'd0, ok);
        if (ok) begin
            wait_rsp(lat);
            chk("hold.latency", 32'(lat), 32'd2);
            for (int k = 0; k < 5; k++) begin
                chk("hold.rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("hold.rsp_pass", 32'(bus.rsp_pass), 32'd1);
                chk("hold.rsp_got", bus.rsp_got, 32'd0);
                chk("hold.cmd_ready", 32'(bus.cmd_ready), 32'd0);
                @(negedge clk);
            end
            finish_rsp(OP_CHECK, 1'b1, "hold");
        end
        run_vec(vecs[8], "clear2");

        // WAIT with unlimited budget, satisfied by a late write to the flag register.
        send_cmd(OP_WAIT, 5'd20, 32'd5, 32'hFFFFFFFF, 16'd0, ok);
        if (ok) begin
            early = 0;
            repeat (40) begin
                if (bus.rsp_valid) early++;
                @(negedge clk);
            end
            chk("late.no_early_rsp", 32'(early), 32'd0);
            wb_write(5'd20, 32'd5);
            chk("late.rsp_not_yet", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            chk("late.rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("late.rsp_pass", 32'(bus.rsp_pass), 32'd1);
            chk("late.rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
            chk("late.rsp_got", bus.rsp_got, 32'd5);
            chk("late.flag", flag, 32'd5);
            if (bus.rsp_valid) finish_rsp(OP_WAIT, 1'b1, "late");
        end

        // Reset in the middle of a pending WAIT: abort, no response.
        send_cmd(OP_WAIT, 5'd20, 32'd7, 32'hFFFFFFFF, 16'd0, ok);
        repeat (3) @(negedge clk);
        do_reset();
        early = 0;
        lat = 0;
        while (!bus.cmd_ready && lat < 5) begin
            if (bus.rsp_valid) early++;
            @(negedge clk);
            lat++;
        end
        chk("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort.no_rsp", 32'(early), 32'd0);
        run_vec('{OP_CHECK, 5'd20, 32'h0, 32'hFFFFFFFF, 16'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 2}, "abort.x20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
